nabp_multibank_swap_control: RTL
================================

NABP_MULTIBANK_SWAP_CONTROL -- requirements
Module: nabp_multibank_swap_control

Interface
REQ-001 SHALL have parameter kDataLength, default 16, filtered sample width (DW).
REQ-002 SHALL have parameter kSLength, default 8, sample index width (SW); bank depth 2^SW.
REQ-003 SHALL have parameter kAngleLength, default 8, angle tag width (AW).
REQ-004 SHALL have parameter kNoOfBanks, default 3, bank count NB, legal range 2..8.
REQ-005 SHALL have parameter kNoOfReadPorts, default 2, independent read ports NR, legal range 1..4.
REQ-006 SHALL have port clk  in  1  sole clock, rising edge.
REQ-007 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-008 SHALL have port hs_angle  in  AW  angle tag of the projection being offered.
REQ-009 SHALL have port hs_has_next_angle  in  1  producer has a projection ready to fill.
REQ-010 SHALL have port hs_val  in  DW  filtered sample for the current index.
REQ-011 SHALL have port hs_next_angle_ack  out  1  one-cycle pulse when a bank is allocated.
REQ-012 SHALL have port hs_s_val  out  SW  sample index being written.
REQ-013 SHALL have port hs_next_angle  out  1  one-cycle pulse on the last write of a fill.
REQ-014 SHALL have port pr_next_angle  in  1  consumer releases the current read bank.
REQ-015 SHALL have port pr_s_val  in  NR*SW  read indices; port i at [SW*(i+1)-1:SW*i].
REQ-016 SHALL have port pr_has_next_angle  out  1  a read bank is held and valid.
REQ-017 SHALL have port pr_next_angle_ack  out  1  one-cycle pulse when a read bank is acquired.
REQ-018 SHALL have port pr_angle  out  AW  angle tag of the held read bank.
REQ-019 SHALL have port pr_val  out  NR*DW  read data, same slicing as pr_s_val.
REQ-020 SHALL have port occupancy  out  4  number of banks not FREE.

Function
REQ-021 Each bank SHALL hold state FREE, FILLING, FULL or READING, plus a latched angle tag.
REQ-022 Banks SHALL be allocated for write strictly in ring order via wr_ptr and read in ring order via rd_ptr, both wrapping NB-1 -> 0.
REQ-023 Write FSM W_IDLE: if hs_has_next_angle=1 and bank[wr_ptr] is FREE, latch hs_angle, mark FILLING, pulse hs_next_angle_ack, clear the index counter, enter W_FILL.
REQ-024 W_FILL SHALL write hs_val to bank[wr_ptr][hs_s_val] every cycle, with hs_s_val incrementing by 1 per cycle from 0.
REQ-025 At hs_s_val=2^SW-1, the block SHALL pulse hs_next_angle, mark the bank FULL, advance wr_ptr, and return to W_IDLE; a fill therefore takes exactly 2^SW cycles.
REQ-026 Deassertion of hs_has_next_angle during W_FILL SHALL NOT abort the fill; hs_val in W_IDLE SHALL be ignored.
REQ-027 Read FSM R_IDLE: if bank[rd_ptr] is FULL, mark READING, load pr_angle, pulse pr_next_angle_ack, set pr_has_next_angle=1, enter R_ACTIVE.
REQ-028 R_ACTIVE: pr_next_angle=1 SHALL mark the bank FREE, advance rd_ptr, clear pr_has_next_angle next cycle, and return to R_IDLE; pr_next_angle in R_IDLE SHALL be ignored.
REQ-029 pr_val[i] SHALL equal bank[rd_ptr][pr_s_val[i]] registered with 1-cycle latency while in R_ACTIVE, and 0 otherwise.
REQ-030 State changes SHALL become visible only on the next edge: the earliest pr_next_angle_ack is 1 cycle after hs_next_angle, and a released bank is reallocatable 1 cycle after the release.
REQ-031 A simultaneous allocate-and-release on different banks SHALL both take effect; occupancy SHALL change by net +0.
REQ-032 When all NB banks are non-FREE, hs_next_angle_ack SHALL stay 0 (backpressure) and no sample SHALL be written.
REQ-033 occupancy SHALL be registered and always equal the count of non-FREE banks.

Reset
REQ-034 reset_n=0 SHALL immediately force all banks FREE, wr_ptr=rd_ptr=0, both FSMs idle, and every output 0, including mid-fill or mid-read; bank contents need not be cleared.

Verification
REQ-035 Single angle (SW=3, NB=3): hs_angle=0x15, hs_val=10+index -> ack pulse, 8 writes, hs_next_angle at index 7, pr_next_angle_ack next cycle, pr_angle=0x15, pr_s_val=5 -> pr_val=15 one cycle later.
REQ-036 Backpressure: produce 4 angles, consumer idle -> 3 acks, occupancy=3, 4th held; one pr_next_angle -> 4th ack 1 cycle after release, fills into bank 0.
REQ-037 Multi-port read (NR=2): ports at indices 0 and 7 in the same cycle -> both data values correct and independent.
REQ-038 Wrap-around: 7 angles streamed with NB=3 -> pr_angle order matches hs_angle order, no data corruption across reuse.
REQ-039 Reset at fill index 4 -> outputs 0 at once; after release, a new angle fills bank 0 from index 0 with occupancy=1.
REQ-040 Spurious pr_next_angle while R_IDLE and empty -> no state change, occupancy stays 0.

Source files
------------

// File: rtl/nabp_multibank_swap_control.sv
// Multi-bank ping-pong store between a filtered-projection producer and a
// multi-port backprojection reader; banks are handed over in ring order.
module nabp_multibank_swap_control #(
  parameter int kDataLength    = 16,
  parameter int kSLength       = 8,
  parameter int kAngleLength   = 8,
  parameter int kNoOfBanks     = 3,
  parameter int kNoOfReadPorts = 2
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [kAngleLength-1:0]              hs_angle,
  input  logic                                 hs_has_next_angle,
  input  logic [kDataLength-1:0]               hs_val,
  output logic                                 hs_next_angle_ack,
  output logic [kSLength-1:0]                  hs_s_val,
  output logic                                 hs_next_angle,
  input  logic                                 pr_next_angle,
  input  logic [kNoOfReadPorts*kSLength-1:0]   pr_s_val,
  output logic                                 pr_has_next_angle,
  output logic                                 pr_next_angle_ack,
  output logic [kAngleLength-1:0]              pr_angle,
  output logic [kNoOfReadPorts*kDataLength-1:0] pr_val,
  output logic [3:0]                           occupancy
);

  localparam int DW    = kDataLength;
  localparam int SW    = kSLength;
  localparam int AW    = kAngleLength;
  localparam int NB    = kNoOfBanks;
  localparam int NR    = kNoOfReadPorts;
  localparam int DEPTH = 2 ** SW;
  localparam int PW    = $clog2(NB);

  typedef enum logic [1:0] {B_FREE, B_FILLING, B_FULL, B_READING} bank_state_e;
  typedef enum logic {W_IDLE, W_FILL} wr_state_e;
  typedef enum logic {R_IDLE, R_ACTIVE} rd_state_e;

  bank_state_e           bank_q [NB];
  bank_state_e           bank_d [NB];
  logic [AW-1:0]         tag_q  [NB];
  logic [DW-1:0]         mem_q  [NB][DEPTH];

  wr_state_e             wr_state_q;
  rd_state_e             rd_state_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [SW-1:0]         idx_q;
  logic                  wr_ack_q, wr_last_q, rd_ack_q, rd_has_q;
  logic [AW-1:0]         pr_angle_q;
  logic [NR*DW-1:0]      pr_val_q;
  logic [3:0]            occ_q, occ_d;

  logic complete, release_now, allocate, acquire;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(NB - 1)) ? '0 : p + PW'(1);
  endfunction

  // A bank finishing its fill or being released this cycle is handed to the
  // other side at the same edge, so hand-over costs one cycle, not two.
  assign complete    = (wr_state_q == W_FILL) && (&idx_q);
  assign release_now = (rd_state_q == R_ACTIVE) && pr_next_angle;
  assign allocate    = (wr_state_q == W_IDLE) && hs_has_next_angle &&
                       ((bank_q[wr_ptr_q] == B_FREE) || (release_now && (rd_ptr_q == wr_ptr_q)));
  assign acquire     = (rd_state_q == R_IDLE) &&
                       ((bank_q[rd_ptr_q] == B_FULL) || (complete && (wr_ptr_q == rd_ptr_q)));

  always_comb begin
    for (int b = 0; b < NB; b++) bank_d[b] = bank_q[b];
    if (release_now) bank_d[rd_ptr_q] = B_FREE;
    if (complete)    bank_d[wr_ptr_q] = B_FULL;
    if (allocate)    bank_d[wr_ptr_q] = B_FILLING;
    if (acquire)     bank_d[rd_ptr_q] = B_READING;
    occ_d = '0;
    for (int b = 0; b < NB; b++) begin
      if (bank_d[b] != B_FREE) occ_d = occ_d + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NB; b++) begin
        bank_q[b] <= B_FREE;
        tag_q[b]  <= '0;
      end
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      idx_q      <= '0;
      wr_ack_q   <= 1'b0;
      wr_last_q  <= 1'b0;
      rd_ack_q   <= 1'b0;
      rd_has_q   <= 1'b0;
      pr_angle_q <= '0;
      pr_val_q   <= '0;
      occ_q      <= '0;
    end else begin
      for (int b = 0; b < NB; b++) bank_q[b] <= bank_d[b];
      occ_q     <= occ_d;
      wr_ack_q  <= 1'b0;
      wr_last_q <= 1'b0;
      rd_ack_q  <= 1'b0;

      case (wr_state_q)
        W_IDLE: begin
          if (allocate) begin
            tag_q[wr_ptr_q] <= hs_angle;
            idx_q           <= '0;
            wr_ack_q        <= 1'b1;
            wr_state_q      <= W_FILL;
          end
        end
        W_FILL: begin
          if (&idx_q) begin
            idx_q      <= '0;
            wr_ptr_q   <= nextPtr(wr_ptr_q);
            wr_state_q <= W_IDLE;
          end else begin
            idx_q     <= idx_q + SW'(1);
            wr_last_q <= (idx_q == SW'(DEPTH - 2));
          end
        end
      endcase

      case (rd_state_q)
        R_IDLE: begin
          if (acquire) begin
            pr_angle_q <= tag_q[rd_ptr_q];
            rd_ack_q   <= 1'b1;
            rd_has_q   <= 1'b1;
            rd_state_q <= R_ACTIVE;
          end
        end
        R_ACTIVE: begin
          if (pr_next_angle) begin
            rd_ptr_q   <= nextPtr(rd_ptr_q);
            rd_has_q   <= 1'b0;
            rd_state_q <= R_IDLE;
          end
        end
      endcase

      for (int i = 0; i < NR; i++) begin
        pr_val_q[i*DW +: DW] <= (rd_state_q == R_ACTIVE) ?
                                mem_q[rd_ptr_q][pr_s_val[i*SW +: SW]] : '0;
      end
    end
  end

  // Sample storage carries no reset; stale contents are never exposed.
  always_ff @(posedge clk) begin
    if (wr_state_q == W_FILL) mem_q[wr_ptr_q][idx_q] <= hs_val;
  end

  assign hs_next_angle_ack = wr_ack_q;
  assign hs_s_val          = idx_q;
  assign hs_next_angle     = wr_last_q;
  assign pr_has_next_angle = rd_has_q;
  assign pr_next_angle_ack = rd_ack_q;
  assign pr_angle          = pr_angle_q;
  assign pr_val            = pr_val_q;
  assign occupancy         = occ_q;

endmodule
